// File: rtl/demux_rr_dispatcher_if.sv
// Bundle of producer/consumer signals for demux_rr_dispatcher.
// dispatch_cnt exists only when DISPATCH_CNT_EN is defined.
interface demux_rr_dispatcher_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         chan_mask;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [DATA_W-1:0]  out_data0;
  logic [DATA_W-1:0]  out_data1;
  logic [DATA_W-1:0]  out_data2;
  logic [DATA_W-1:0]  out_data3;
  logic [1:0]         sel;
`ifdef DISPATCH_CNT_EN
  logic [4*CNT_W-1:0] dispatch_cnt;
`endif

  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("demux_rr_dispatcher_if: DATA_W and CNT_W must be at least 1");
  end

  // master: producer plus consumers; slave: the dispatcher
  modport master (
`ifdef DISPATCH_CNT_EN
    input  dispatch_cnt,
`endif
    output in_data, in_valid, chan_mask, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, sel
  );

  modport slave (
`ifdef DISPATCH_CNT_EN
    output dispatch_cnt,
`endif
    input  in_data, in_valid, chan_mask, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, sel
  );
endinterface

// File: rtl/demux_rr_dispatcher.sv
// One-entry holding register feeding a round-robin 1x4 demux.
// Define DISPATCH_CNT_EN to add per-channel delivered-word counters.
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_EMPTY | holding register free, in_ready=1
// ST_ARB   | word held, searching chan_mask for next eligible channel
// ST_SEND  | out_valid[sel] asserted until out_ready[sel] handshakes
module demux_rr_dispatcher #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  demux_rr_dispatcher_if.slave bus
);
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("demux_rr_dispatcher: DATA_W and CNT_W must be at least 1");
  end

  logic [1:0]        state;
  logic [1:0]        sel_q;
  logic [1:0]        last_grant;
  logic [DATA_W-1:0] hold_data;
  logic              grant_found;
  logic [1:0]        grant;
  logic              handshake;

  // offset 4 wraps to last_grant itself, so a lone repeat channel is still found
  always_comb begin
    grant_found = 1'b0;
    grant       = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      if (!grant_found && bus.chan_mask[last_grant + 2'(i)]) begin
        grant_found = 1'b1;
        grant       = last_grant + 2'(i);
      end
    end
  end

  assign handshake = (state == ST_SEND) && bus.out_ready[sel_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      sel_q      <= 2'd0;
      last_grant <= 2'd3;
      hold_data  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (bus.in_valid) begin
            hold_data <= bus.in_data;
            state     <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (grant_found) begin
            sel_q <= grant;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (handshake) begin
            last_grant <= sel_q;
            state      <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_EMPTY);
  assign bus.sel       = sel_q;
  assign bus.out_valid = (state == ST_SEND) ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.out_data0 = (state == ST_SEND && sel_q == 2'd0) ? hold_data : '0;
  assign bus.out_data1 = (state == ST_SEND && sel_q == 2'd1) ? hold_data : '0;
  assign bus.out_data2 = (state == ST_SEND && sel_q == 2'd2) ? hold_data : '0;
  assign bus.out_data3 = (state == ST_SEND && sel_q == 2'd3) ? hold_data : '0;

`ifdef DISPATCH_CNT_EN
  logic [3:0][CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (handshake) begin
      cnt[sel_q] <= cnt[sel_q] + CNT_W'(1);
    end
  end

  assign bus.dispatch_cnt = cnt;
`endif
endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Self-checking bench for demux_rr_dispatcher: directed table, corner sequences,
// then randomized transfers against a round-robin reference model.
module tb_demux_rr_dispatcher;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_rr_dispatcher_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  demux_rr_dispatcher #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int model_last = 3;
  int model_cnt [4];

  typedef struct {
    logic [3:0] mask;
    logic [7:0] data;
    int         exp_ch;
    int         stall;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_bus();
    return {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0};
  endfunction

  // first set mask bit after the last granted channel, wrapping around
  function automatic int model_grant(input logic [3:0] m);
    for (int i = 1; i <= 4; i++)
      if (m[(model_last + i) % 4]) return (model_last + i) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    model_last = 3;
    for (int k = 0; k < 4; k++) model_cnt[k] = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_data"}, data_bus(), 32'd0);
  endtask

  // Called at a negedge in EMPTY; returns at a negedge back in EMPTY.
  task automatic xfer(input logic [7:0] d, input logic [3:0] mask, input int exp_ch,
                      input int stall);
    logic [3:0] onehot;
    onehot = 4'b0001 << exp_ch;
    chk("accept_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.chan_mask = mask;
    bus.out_ready = 4'($urandom);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    chk("arb_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arb_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    for (int s = 0; s <= stall; s++) begin
      chk("send_out_valid", 32'(bus.out_valid), 32'(onehot));
      chk("send_sel", 32'(bus.sel), 32'(exp_ch));
      chk("send_out_data", data_bus(), 32'(d) << (8 * exp_ch));
      chk("send_in_ready", 32'(bus.in_ready), 32'd0);
      bus.chan_mask = 4'($urandom);
      if (s < stall) bus.out_ready = 4'($urandom) & ~onehot;
      else           bus.out_ready = 4'($urandom) | onehot;
      @(negedge clk);
    end
    check_idle("done");
    model_last = exp_ch;
    model_cnt[exp_ch] = (model_cnt[exp_ch] + 1) % (1 << CNT_W);
  endtask

`ifdef DISPATCH_CNT_EN
  task automatic check_counts(input int c0, input int c1, input int c2, input int c3);
    chk("cnt0", 32'(bus.dispatch_cnt[0*CNT_W +: CNT_W]), 32'(c0));
    chk("cnt1", 32'(bus.dispatch_cnt[1*CNT_W +: CNT_W]), 32'(c1));
    chk("cnt2", 32'(bus.dispatch_cnt[2*CNT_W +: CNT_W]), 32'(c2));
    chk("cnt3", 32'(bus.dispatch_cnt[3*CNT_W +: CNT_W]), 32'(c3));
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] m;
    logic [7:0] d;
    int         ch;

    tbl[0] = '{4'b1111, 8'hA1, 0, 0};
    tbl[1] = '{4'b1111, 8'hA2, 1, 0};
    tbl[2] = '{4'b1111, 8'hA3, 2, 0};
    tbl[3] = '{4'b1111, 8'hA4, 3, 0};
    tbl[4] = '{4'b1111, 8'hA5, 0, 0};
    tbl[5] = '{4'b1010, 8'h11, 1, 0};
    tbl[6] = '{4'b1010, 8'h22, 3, 0};
    tbl[7] = '{4'b1010, 8'h33, 1, 0};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.chan_mask = 4'b1111;
    bus.out_ready = 4'b0000;
    model_reset();

    @(negedge clk);
    check_idle("reset");
    chk("reset_sel", 32'(bus.sel), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // rst asserted mid-cycle while a word is being offered on a channel
    bus.in_valid = 1'b1; bus.in_data = 8'hE7; bus.chan_mask = 4'b0100; bus.out_ready = 4'b0000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'b0100);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    chk("async_rst_sel", 32'(bus.sel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i].data, tbl[i].mask, tbl[i].exp_ch, tbl[i].stall);
`ifdef DISPATCH_CNT_EN
      if (i == 4) check_counts(2, 1, 1, 1);
`endif
    end

    // no eligible channel: word is held indefinitely
    bus.in_valid = 1'b1; bus.in_data = 8'h5C; bus.chan_mask = 4'b0000; bus.out_ready = 4'hF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) begin
      chk("nomask_in_ready", 32'(bus.in_ready), 32'd0);
      chk("nomask_out_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    bus.chan_mask = 4'b0100;
    @(negedge clk);
    chk("nomask_late_valid", 32'(bus.out_valid), 32'b0100);
    chk("nomask_late_data", data_bus(), 32'h005C_0000);
    @(negedge clk);
    check_idle("nomask_done");
    model_last = 2;
    model_cnt[2]++;

    // stalled SEND on ch1 with mask and out_ready[0] churning
    xfer(8'h77, 4'b0010, 1, 5);

    for (int n = 0; n < 150; n++) begin
      m  = 4'($urandom_range(1, 15));
      d  = 8'($urandom);
      ch = model_grant(m);
      xfer(d, m, ch, int'($urandom_range(0, 3)));
    end

`ifdef DISPATCH_CNT_EN
    check_counts(model_cnt[0], model_cnt[1], model_cnt[2], model_cnt[3]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
